// File: rtl/sprite_palette_ctrl.sv
// Banked sprite palette with a 2-stage lookup pipeline and a frame-timed hit-flash.
// Stage 1 captures the stored entry; stage 2 applies transparency, flash and dimming.
module sprite_palette_ctrl #(
  parameter int INDEX_W      = 4,
  parameter int COLOR_W      = 4,
  parameter int NUM_BANKS    = 2,
  localparam int BANK_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int ENTRIES     = 2 ** INDEX_W,
  localparam int RGB_W       = 3 * COLOR_W,
  parameter logic [ENTRIES*RGB_W-1:0] INIT_TABLE =
    192'h000_FFF_F00_0F0_00F_FF0_0FF_F0F_888_444_F80_8F0_08F_F6A_ABC_123,
  parameter logic [INDEX_W-1:0] TRANSP_INDEX = '0,
  parameter logic [RGB_W-1:0]   FLASH_RGB    = '1,
  parameter int FLASH_FRAMES = 8,
  parameter int FLASH_HALF   = 2
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               rd_valid,
  input  logic [BANK_W-1:0]  rd_bank,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic               wr_en,
  input  logic [BANK_W-1:0]  wr_bank,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [RGB_W-1:0]   wr_rgb,
  input  logic               flash_start,
  input  logic               frame_tick,
  input  logic               dim_en,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               transparent,
  output logic               out_valid,
  output logic               flashing
);

  localparam int REM_W = $clog2(FLASH_FRAMES + 1);
  localparam int PH_W  = (FLASH_HALF > 1) ? $clog2(FLASH_HALF + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } flash_state_e;

  flash_state_e     state_q;
  logic [REM_W-1:0] remaining_q;
  logic [PH_W-1:0]  phase_q;

  logic [RGB_W-1:0] mem_q [NUM_BANKS][ENTRIES];

  logic             s1_valid_q;
  logic             s1_transp_q;
  logic [RGB_W-1:0] s1_rgb_q;

  logic             out_valid_q;
  logic             out_transp_q;
  logic [RGB_W-1:0] out_rgb_q;
  logic             out_transp_d;
  logic [RGB_W-1:0] out_rgb_d;

  logic [BANK_W-1:0] rd_sel;
  logic [BANK_W-1:0] wr_sel;

  // A single bank ignores the select lines entirely.
  assign rd_sel = (NUM_BANKS == 1) ? '0 : rd_bank;
  assign wr_sel = (NUM_BANKS == 1) ? '0 : wr_bank;

  // Palette storage; stage 1 reads the pre-edge contents, so a same-edge write is not seen.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int e = 0; e < ENTRIES; e++) begin
          mem_q[b][e] <= INIT_TABLE[(ENTRIES-1-e)*RGB_W +: RGB_W];
        end
      end
    end else if (wr_en) begin
      mem_q[wr_sel][wr_index] <= wr_rgb;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_transp_q <= 1'b0;
      s1_rgb_q    <= '0;
    end else begin
      s1_valid_q  <= rd_valid;
      s1_transp_q <= (rd_index == TRANSP_INDEX);
      s1_rgb_q    <= mem_q[rd_sel][rd_index];
    end
  end

  // Flash phase and dim_en are taken at the stage-2 edge, not at request time.
  always_comb begin
    out_rgb_d    = '0;
    out_transp_d = 1'b0;
    if (s1_valid_q) begin
      if (s1_transp_q) begin
        out_transp_d = 1'b1;
      end else if (state_q == ST_ON) begin
        out_rgb_d = FLASH_RGB;
      end else if (dim_en) begin
        for (int c = 0; c < 3; c++) begin
          out_rgb_d[c*COLOR_W +: COLOR_W] = s1_rgb_q[c*COLOR_W +: COLOR_W] >> 1;
        end
      end else begin
        out_rgb_d = s1_rgb_q;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid_q  <= 1'b0;
      out_transp_q <= 1'b0;
      out_rgb_q    <= '0;
    end else begin
      out_valid_q  <= s1_valid_q;
      out_transp_q <= out_transp_d;
      out_rgb_q    <= out_rgb_d;
    end
  end

  // flash_start outranks a coincident frame_tick and restarts an active flash.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      phase_q     <= '0;
    end else if (flash_start) begin
      state_q     <= ST_ON;
      remaining_q <= REM_W'(FLASH_FRAMES);
      phase_q     <= '0;
    end else if (frame_tick && (state_q != ST_IDLE)) begin
      remaining_q <= remaining_q - 1'b1;
      if (remaining_q == REM_W'(1)) begin
        state_q <= ST_IDLE;
        phase_q <= '0;
      end else if (phase_q == PH_W'(FLASH_HALF - 1)) begin
        phase_q <= '0;
        state_q <= (state_q == ST_ON) ? ST_OFF : ST_ON;
      end else begin
        phase_q <= phase_q + 1'b1;
      end
    end
  end

  assign red         = out_rgb_q[2*COLOR_W +: COLOR_W];
  assign green       = out_rgb_q[COLOR_W +: COLOR_W];
  assign blue        = out_rgb_q[0 +: COLOR_W];
  assign transparent = out_transp_q;
  assign out_valid   = out_valid_q;
  assign flashing    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sprite_palette_ctrl.sv
// Directed bench for sprite_palette_ctrl: lookups, writes, transparency, dim, flash FSM, reset.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_sprite_palette_ctrl;

  logic        Clk;
  logic        Reset_n;
  logic        rd_valid;
  logic [0:0]  rd_bank;
  logic [3:0]  rd_index;
  logic        wr_en;
  logic [0:0]  wr_bank;
  logic [3:0]  wr_index;
  logic [11:0] wr_rgb;
  logic        flash_start;
  logic        frame_tick;
  logic        dim_en;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        transparent;
  logic        out_valid;
  logic        flashing;

  int checks = 0;
  int errors = 0;

  localparam logic [11:0] INIT_T [16] = '{
    12'h000, 12'hFFF, 12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F,
    12'h888, 12'h444, 12'hF80, 12'h8F0, 12'h08F, 12'hF6A, 12'hABC, 12'h123
  };
  localparam logic FLASH_ON [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  sprite_palette_ctrl dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .rd_valid    (rd_valid),
    .rd_bank     (rd_bank),
    .rd_index    (rd_index),
    .wr_en       (wr_en),
    .wr_bank     (wr_bank),
    .wr_index    (wr_index),
    .wr_rgb      (wr_rgb),
    .flash_start (flash_start),
    .frame_tick  (frame_tick),
    .dim_en      (dim_en),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .transparent (transparent),
    .out_valid   (out_valid),
    .flashing    (flashing)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_entry(input logic [0:0] bank, input logic [3:0] idx, input logic [11:0] rgb);
    wr_en    = 1'b1;
    wr_bank  = bank;
    wr_index = idx;
    wr_rgb   = rgb;
    step();
    wr_en    = 1'b0;
  endtask

  // One request, then confirm nothing appears early and the colour arrives two edges later.
  task automatic read_check(input string tag, input logic [0:0] bank, input logic [3:0] idx,
                            input logic dim, input logic [11:0] exp_rgb, input logic exp_tr);
    rd_valid = 1'b1;
    rd_bank  = bank;
    rd_index = idx;
    dim_en   = dim;
    step();
    rd_valid = 1'b0;
    check_eq({tag, "_early"}, {31'd0, out_valid}, 32'd0);
    step();
    check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, "_rgb"}, {20'd0, red, green, blue}, {20'd0, exp_rgb});
    check_eq({tag, "_tr"}, {31'd0, transparent}, {31'd0, exp_tr});
  endtask

  task automatic pulse_tick(input logic with_start);
    frame_tick  = 1'b1;
    flash_start = with_start;
    step();
    frame_tick  = 1'b0;
    flash_start = 1'b0;
  endtask

  // Walk a full flash from frame 0 and confirm it ends after exactly 8 ticks.
  task automatic flash_run(input string tag);
    for (int f = 0; f < 8; f++) begin
      check_eq($sformatf("%s_flashing_f%0d", tag, f), {31'd0, flashing}, 32'd1);
      read_check($sformatf("%s_f%0d", tag, f), 1'b0, 4'hD, 1'b0,
                 FLASH_ON[f] ? 12'hFFF : 12'hF6A, 1'b0);
      read_check($sformatf("%s_dim_f%0d", tag, f), 1'b0, 4'hD, 1'b1,
                 FLASH_ON[f] ? 12'hFFF : 12'h735, 1'b0);
      pulse_tick(1'b0);
    end
    check_eq({tag, "_done"}, {31'd0, flashing}, 32'd0);
    read_check({tag, "_after"}, 1'b0, 4'hD, 1'b0, 12'hF6A, 1'b0);
  endtask

  initial begin
    Reset_n     = 1'b0;
    rd_valid    = 1'b0;
    rd_bank     = '0;
    rd_index    = '0;
    wr_en       = 1'b0;
    wr_bank     = '0;
    wr_index    = '0;
    wr_rgb      = '0;
    flash_start = 1'b0;
    frame_tick  = 1'b0;
    dim_en      = 1'b0;
    repeat (3) step();
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_rgb", {20'd0, red, green, blue}, 32'd0);
    check_eq("rst_tr", {31'd0, transparent}, 32'd0);
    check_eq("rst_flashing", {31'd0, flashing}, 32'd0);
    Reset_n = 1'b1;
    step();

    read_check("init_b0_i3", 1'b0, 4'h3, 1'b0, 12'h0F0, 1'b0);
    step();
    check_eq("idle_valid", {31'd0, out_valid}, 32'd0);
    check_eq("idle_rgb_zero", {20'd0, red, green, blue}, 32'd0);

    write_entry(1'b1, 4'h5, 12'hABC);
    read_check("wr_b1_i5", 1'b1, 4'h5, 1'b0, 12'hABC, 1'b0);
    read_check("init_b0_i5", 1'b0, 4'h5, 1'b0, 12'hFF0, 1'b0);
    read_check("dim_b0_iE", 1'b0, 4'hE, 1'b1, 12'h556, 1'b0);

    wr_en = 1'b1; wr_bank = 1'b1; wr_index = 4'h5; wr_rgb = 12'h321;
    read_check("rbw_old", 1'b1, 4'h5, 1'b0, 12'hABC, 1'b0);
    wr_en = 1'b0;
    read_check("rbw_new", 1'b1, 4'h5, 1'b0, 12'h321, 1'b0);

    // Back-to-back requests for indices 1..4, one per cycle.
    for (int i = 0; i < 5; i++) begin
      rd_valid = (i < 4);
      rd_bank  = 1'b0;
      rd_index = 4'(i + 1);
      dim_en   = 1'b0;
      step();
      if (i >= 1) begin
        check_eq($sformatf("b2b_valid_%0d", i), {31'd0, out_valid}, 32'd1);
        check_eq($sformatf("b2b_rgb_%0d", i), {20'd0, red, green, blue}, {20'd0, INIT_T[i]});
      end
    end
    rd_valid = 1'b0;

    pulse_tick(1'b0);
    check_eq("idle_tick_flashing", {31'd0, flashing}, 32'd0);
    read_check("idle_tick_rgb", 1'b0, 4'hD, 1'b0, 12'hF6A, 1'b0);

    flash_start = 1'b1;
    step();
    flash_start = 1'b0;
    read_check("transp_flash_dim", 1'b0, 4'h0, 1'b1, 12'h000, 1'b1);
    flash_run("flash");

    // Restart with a coincident tick after three frames of a running flash.
    flash_start = 1'b1;
    step();
    flash_start = 1'b0;
    repeat (3) pulse_tick(1'b0);
    read_check("mid_off", 1'b0, 4'hD, 1'b0, 12'hF6A, 1'b0);
    pulse_tick(1'b1);
    flash_run("restart");

    // Reset with a flash running and requests in flight.
    flash_start = 1'b1;
    step();
    flash_start = 1'b0;
    rd_valid = 1'b1; rd_bank = 1'b0; rd_index = 4'hD; dim_en = 1'b0;
    repeat (3) step();
    check_eq("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    Reset_n = 1'b0;
    #1;
    check_eq("arst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("arst_rgb", {20'd0, red, green, blue}, 32'd0);
    check_eq("arst_flashing", {31'd0, flashing}, 32'd0);
    rd_valid = 1'b0;
    step();
    Reset_n = 1'b1;
    step();
    check_eq("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
    read_check("post_rst_b1_i5", 1'b1, 4'h5, 1'b0, 12'hFF0, 1'b0);
    check_eq("post_rst_flashing", {31'd0, flashing}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
